// File: rtl/clk_meas_pkg.sv
// clk_meas_pkg: shared state encoding, default widths and saturating increment for the period meter
package clk_meas_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, HIGH = 2'd2, LOW = 2'd3} state_t;
   localparam int CNT_W_DEF  = 8;
   localparam int PCNT_W_DEF = 16;
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
      return (v == (32'hFFFF_FFFF >> (32 - w))) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/clk_period_meter_edge_det.sv
// edge_det: registers the sampled divided clock and flags its rising and falling edges
module edge_det (
   input  logic clk_in,
   input  logic reset,
   input  logic sig_in,
   output logic rise,
   output logic fall
);
   logic sig_d;
   always_ff @(posedge clk_in) begin
      if (reset) sig_d <= 1'b0;
      else       sig_d <= sig_in;
   end
   assign rise = sig_in & ~sig_d;
   assign fall = ~sig_in & sig_d;
endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures high/low time of a divided clock and checks it against expected values
module clk_period_meter
   import clk_meas_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int PCNT_W = PCNT_W_DEF
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              en,
   input  logic              clr,
   input  logic              sig_in,
   input  logic [CNT_W-1:0]  exp_high,
   input  logic [CNT_W-1:0]  exp_low,
   output logic [CNT_W-1:0]  meas_high,
   output logic [CNT_W-1:0]  meas_low,
   output logic              meas_valid,
   output logic              mismatch,
   output logic [PCNT_W-1:0] period_cnt,
   output logic              busy
);
   state_t state, state_nx;
   logic rise, fall, sat, done, fail;
   logic [CNT_W-1:0] hcnt, lcnt;
   logic [PCNT_W-1:0] pbase;
   edge_det u_edge (.clk_in(clk_in), .reset(reset), .sig_in(sig_in), .rise(rise), .fall(fall));
   always_comb begin
      state_nx = !en             ? IDLE :
                 state == IDLE   ? ARM  :
                 state == ARM    ? (rise ? HIGH : ARM) :
                 state == HIGH   ? (fall ? LOW : HIGH) :
                                   (rise ? HIGH : LOW);
   end
   assign done  = en && state == LOW && rise;
   assign fail  = (exp_high != '0 && hcnt != exp_high) || (exp_low != '0 && lcnt != exp_low) || sat;
   assign pbase = clr ? '0 : period_cnt;
   assign busy  = state == HIGH || state == LOW;
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state      <= IDLE;
         hcnt       <= '0;
         lcnt       <= '0;
         sat        <= 1'b0;
         meas_high  <= '0;
         meas_low   <= '0;
         meas_valid <= 1'b0;
         mismatch   <= 1'b0;
         period_cnt <= '0;
      end else begin
         state      <= state_nx;
         meas_valid <= done;
         mismatch   <= (mismatch & ~clr) | (done & fail);
         period_cnt <= done ? PCNT_W'(sat_inc(32'(pbase), PCNT_W)) : pbase;
         if (done) begin
            meas_high <= hcnt;
            meas_low  <= lcnt;
         end
         // Counters only run while measuring; leaving or arming starts from a clean slate
         if (!en || state == IDLE || state == ARM) begin
            hcnt <= (en && state == ARM && rise) ? CNT_W'(1) : '0;
            lcnt <= '0;
            sat  <= 1'b0;
         end else if (state == HIGH) begin
            if (fall) lcnt <= CNT_W'(1);
            else if (sig_in) begin
               hcnt <= CNT_W'(sat_inc(32'(hcnt), CNT_W));
               sat  <= sat | (&hcnt);
            end
         end else if (rise) begin
            hcnt <= CNT_W'(1);
            lcnt <= '0;
            sat  <= 1'b0;
         end else begin
            lcnt <= CNT_W'(sat_inc(32'(lcnt), CNT_W));
            sat  <= sat | (&lcnt);
         end
      end
   end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: scoreboard bench for clk_period_meter using scripted divided-clock waveforms
module tb_clk_period_meter;
   logic clk_in = 1'b0, reset = 1'b1, en = 1'b0, clr = 1'b0, sig_in = 1'b0;
   logic [7:0] exp_high = '0, exp_low = '0, meas_high, meas_low;
   logic meas_valid, mismatch, busy;
   logic [15:0] period_cnt;
   typedef struct {int h; int l; bit mm; int pc;} exp_t;
   exp_t sbq[$];
   int n_cmp = 0, n_bad = 0;
   bit m_mm;
   int m_pc;

   clk_period_meter dut (
      .clk_in(clk_in), .reset(reset), .en(en), .clr(clr), .sig_in(sig_in),
      .exp_high(exp_high), .exp_low(exp_low), .meas_high(meas_high), .meas_low(meas_low),
      .meas_valid(meas_valid), .mismatch(mismatch), .period_cnt(period_cnt), .busy(busy)
   );

   always #5 clk_in = ~clk_in;

   // Monitor: every result pulse must match the next queued expectation
   initial forever begin
      @(posedge clk_in);
      #1;
      if (meas_valid === 1'b1) begin
         n_cmp++;
         if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_valid: got meas %0d/%0d, required no result", meas_high, meas_low);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            n_cmp += 3;
            if (meas_high !== e.h[7:0]) begin n_bad++; $display("FAIL meas_high: got %0d required %0d", meas_high, e.h); end
            if (meas_low !== e.l[7:0]) begin n_bad++; $display("FAIL meas_low: got %0d required %0d", meas_low, e.l); end
            if (mismatch !== e.mm) begin n_bad++; $display("FAIL mismatch: got %0b required %0b", mismatch, e.mm); end
            if (period_cnt !== e.pc[15:0]) begin n_bad++; $display("FAIL period_cnt: got %0d required %0d", period_cnt, e.pc); end
         end
      end
   end

   task automatic cyc(input logic v);
      sig_in = v;
      @(posedge clk_in);
      #1;
   endtask

   task automatic phase(input logic v, input int n);
      repeat (n) cyc(v);
   endtask

   // Push the result the DUT should report when the period of h high / l low cycles completes
   task automatic expect_period(input int h, input int l);
      bit f;
      f = (exp_high != 0 && h != int'(exp_high)) || (exp_low != 0 && l != int'(exp_low)) || h > 255 || l > 255;
      m_mm = m_mm | f;
      m_pc = (m_pc == 65535) ? m_pc : m_pc + 1;
      sbq.push_back('{h > 255 ? 255 : h, l > 255 ? 255 : l, m_mm, m_pc});
   endtask

   task automatic do_reset();
      reset = 1'b1; en = 1'b0; clr = 1'b0; sig_in = 1'b0;
      phase(0, 2);
      reset = 1'b0;
      m_mm = 0; m_pc = 0;
      sbq.delete();
   endtask

   task automatic test_reset();
      do_reset();
      phase(1, 2); phase(0, 2); phase(1, 2);
      n_cmp += 6;
      if (meas_high !== 8'd0) begin n_bad++; $display("FAIL rst_meas_high: got %0d required 0", meas_high); end
      if (meas_low !== 8'd0) begin n_bad++; $display("FAIL rst_meas_low: got %0d required 0", meas_low); end
      if (meas_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b required 0", meas_valid); end
      if (mismatch !== 1'b0) begin n_bad++; $display("FAIL rst_mismatch: got %0b required 0", mismatch); end
      if (period_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_period_cnt: got %0d required 0", period_cnt); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b required 0", busy); end
   endtask

   task automatic test_f6();
      do_reset();
      exp_high = 8'd3; exp_low = 8'd3; en = 1'b1;
      cyc(1); phase(1, 2); phase(0, 3);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) expect_period(3, 3);
         phase(1, 3); phase(0, 3);
      end
      expect_period(3, 3);
      cyc(1);
      n_cmp += 3;
      if (period_cnt !== 16'd4) begin n_bad++; $display("FAIL f6_period_cnt: got %0d required 4", period_cnt); end
      if (mismatch !== 1'b0) begin n_bad++; $display("FAIL f6_mismatch: got %0b required 0", mismatch); end
      if (sbq.size() != 0) begin n_bad++; $display("FAIL f6_drain: got %0d pending required 0", sbq.size()); end
   endtask

   task automatic test_f2();
      do_reset();
      exp_high = 8'd1; exp_low = 8'd1; en = 1'b1;
      cyc(0); cyc(1); cyc(0);
      for (int k = 0; k < 4; k++) begin
         expect_period(1, 1);
         cyc(1);
         n_cmp++;
         if (meas_valid !== 1'b1) begin n_bad++; $display("FAIL f2_pulse: got %0b required 1", meas_valid); end
         cyc(0);
         n_cmp++;
         if (meas_valid !== 1'b0) begin n_bad++; $display("FAIL f2_gap: got %0b required 0", meas_valid); end
      end
      n_cmp++;
      if (sbq.size() != 0) begin n_bad++; $display("FAIL f2_drain: got %0d pending required 0", sbq.size()); end
   endtask

   task automatic test_clr();
      do_reset();
      exp_high = 8'd3; exp_low = 8'd3; en = 1'b1;
      cyc(0);
      phase(1, 4); phase(0, 2);
      expect_period(4, 2);
      phase(1, 4); phase(0, 2);
      expect_period(4, 2);
      phase(1, 3);
      clr = 1'b1; cyc(1); clr = 1'b0;
      m_mm = 0; m_pc = 0;
      n_cmp += 2;
      if (mismatch !== 1'b0) begin n_bad++; $display("FAIL clr_mismatch: got %0b required 0", mismatch); end
      if (period_cnt !== 16'd0) begin n_bad++; $display("FAIL clr_period_cnt: got %0d required 0", period_cnt); end
      phase(0, 2);
      clr = 1'b1;
      m_mm = 0; m_pc = 0;
      expect_period(4, 2);
      cyc(1);
      clr = 1'b0;
      n_cmp += 3;
      if (mismatch !== 1'b1) begin n_bad++; $display("FAIL clr_coinc_mismatch: got %0b required 1", mismatch); end
      if (period_cnt !== 16'd1) begin n_bad++; $display("FAIL clr_coinc_period_cnt: got %0d required 1", period_cnt); end
      if (sbq.size() != 0) begin n_bad++; $display("FAIL clr_drain: got %0d pending required 0", sbq.size()); end
   endtask

   task automatic test_saturation();
      do_reset();
      exp_high = 8'd0; exp_low = 8'd5; en = 1'b1;
      cyc(0);
      phase(1, 300); phase(0, 5);
      expect_period(300, 5);
      cyc(1);
      phase(1, 9); phase(0, 5);
      expect_period(10, 5);
      cyc(1);
      n_cmp += 2;
      if (mismatch !== 1'b1) begin n_bad++; $display("FAIL sat_sticky: got %0b required 1", mismatch); end
      if (sbq.size() != 0) begin n_bad++; $display("FAIL sat_drain: got %0d pending required 0", sbq.size()); end
   endtask

   task automatic test_reset_mid_high();
      do_reset();
      exp_high = 8'd2; exp_low = 8'd2; en = 1'b1;
      cyc(0);
      phase(1, 2); phase(0, 2);
      expect_period(2, 2);
      cyc(1);
      reset = 1'b1; cyc(1); reset = 1'b0;
      m_mm = 0; m_pc = 0;
      n_cmp += 5;
      if (meas_high !== 8'd0 || meas_low !== 8'd0) begin n_bad++; $display("FAIL midrst_meas: got %0d/%0d required 0/0", meas_high, meas_low); end
      if (meas_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %0b required 0", meas_valid); end
      if (mismatch !== 1'b0) begin n_bad++; $display("FAIL midrst_mismatch: got %0b required 0", mismatch); end
      if (period_cnt !== 16'd0) begin n_bad++; $display("FAIL midrst_period_cnt: got %0d required 0", period_cnt); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %0b required 0", busy); end
      cyc(1); phase(0, 2);
      phase(1, 2); phase(0, 2);
      expect_period(2, 2);
      cyc(1);
      n_cmp++;
      if (sbq.size() != 0) begin n_bad++; $display("FAIL midrst_drain: got %0d pending required 0", sbq.size()); end
   endtask

   task automatic test_en_drop();
      do_reset();
      exp_high = 8'd2; exp_low = 8'd2; en = 1'b1;
      cyc(0);
      phase(1, 2); phase(0, 2);
      expect_period(2, 2);
      phase(1, 2);
      cyc(0);
      en = 1'b0;
      cyc(0);
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL endrop_busy: got %0b required 0", busy); end
      cyc(1);
      n_cmp += 3;
      if (meas_valid !== 1'b0) begin n_bad++; $display("FAIL endrop_valid: got %0b required 0", meas_valid); end
      if (meas_high !== 8'd2 || meas_low !== 8'd2) begin n_bad++; $display("FAIL endrop_hold: got %0d/%0d required 2/2", meas_high, meas_low); end
      if (period_cnt !== 16'd1) begin n_bad++; $display("FAIL endrop_period_cnt: got %0d required 1", period_cnt); end
      phase(1, 1); phase(0, 2);
      en = 1'b1;
      cyc(0);
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL rearm_busy: got %0b required 0", busy); end
      phase(1, 2);
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL rearm_high_busy: got %0b required 1", busy); end
      phase(0, 2);
      expect_period(2, 2);
      cyc(1);
      n_cmp++;
      if (sbq.size() != 0) begin n_bad++; $display("FAIL rearm_drain: got %0d pending required 0", sbq.size()); end
   endtask

   initial begin
      test_reset();
      test_f6();
      test_f2();
      test_clr();
      test_saturation();
      test_reset_mid_high();
      test_en_drop();
      phase(0, 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
